// File: rtl/my_cpu.sv
// Multi-cycle 16-bit load/store core: fetch (INF) then one or two execute cycles.
// One shared address/data bus; iom_out steers an access to I/O space instead of memory.
module my_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] d_in,
  input  logic [15:0] io_in,
  output logic [15:0] a_out,
  output logic [15:0] d_out,
  output logic        wen_out,
  output logic        iom_out
);
  typedef enum logic [1:0] {INF = 2'd0, EX0 = 2'd1, EX1 = 2'd2, HLT = 2'd3} st_t;
  typedef enum logic [1:0] {PS_HOLD, PS_INC, PS_BR, PS_JMP} ps_t;

  localparam logic [6:0] OP_MOVA = 7'b0000000, OP_INC = 7'b0000001, OP_ADD = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101, OP_DEC = 7'b0000110, OP_AND = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001, OP_XOR = 7'b0001010, OP_NOT = 7'b0001011;
  localparam logic [6:0] OP_MOVB = 7'b0001100, OP_SHR = 7'b0001101, OP_SHL = 7'b0001110;
  localparam logic [6:0] OP_LDI  = 7'b1001100, OP_ADI = 7'b1000010, OP_LD  = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000, OP_IN  = 7'b0010001, OP_OUT = 7'b0100001;
  localparam logic [6:0] OP_LRI  = 7'b0010100, OP_BRZ = 7'b1100000, OP_BRN = 7'b1100001;
  localparam logic [6:0] OP_JMP  = 7'b1110000, OP_HLT = 7'b1111111;

  st_t         st_r, st_d;
  ps_t         ps;
  logic [15:0] pc_r, ir_r;
  logic [15:0] rb_r [8];
  logic [15:0] hb_r [8];
  logic [1:0]  nz;
  logic        nz_unused;
  logic [15:0] abus, bbus, dbus, fu_res, br_off;
  logic        fu_alu, il, rf_we, nz_we, h0_we;
  logic [7:0]  rf_sel;
  logic [15:0] a_int, d_int;
  logic        wen_int, iom_int;

  logic [6:0] op;
  logic [2:0] dr, sa, sb;
  assign op = ir_r[15:9];
  assign dr = ir_r[8:6];
  assign sa = ir_r[5:3];
  assign sb = ir_r[2:0];

  assign abus   = rb_r[sa];
  assign bbus   = rb_r[sb];
  assign br_off = {{10{ir_r[8]}}, ir_r[8:6], ir_r[2:0]};

  // Flags are architectural state only; no instruction consumes them.
  assign nz_unused = ^nz;

  always_comb begin
    fu_res = '0;
    fu_alu = 1'b1;
    case (op)
      OP_MOVA: fu_res = abus;
      OP_INC:  fu_res = abus + 16'd1;
      OP_ADD:  fu_res = abus + bbus;
      OP_SUB:  fu_res = abus - bbus;
      OP_DEC:  fu_res = abus - 16'd1;
      OP_AND:  fu_res = abus & bbus;
      OP_OR:   fu_res = abus | bbus;
      OP_XOR:  fu_res = abus ^ bbus;
      OP_NOT:  fu_res = ~abus;
      OP_MOVB: fu_res = bbus;
      OP_SHR:  fu_res = {1'b0, bbus[15:1]};
      OP_SHL:  fu_res = {bbus[14:0], 1'b0};
      OP_LDI:  fu_res = {13'd0, sb};
      OP_ADI:  fu_res = abus + {13'd0, sb};
      default: fu_alu = 1'b0;
    endcase
  end

  always_comb begin
    st_d    = st_r;
    ps      = PS_HOLD;
    il      = 1'b0;
    rf_we   = 1'b0;
    nz_we   = 1'b0;
    h0_we   = 1'b0;
    dbus    = fu_res;
    a_int   = pc_r;
    d_int   = '0;
    wen_int = 1'b1;
    iom_int = 1'b0;
    case (st_r)
      INF: begin
        il   = 1'b1;
        st_d = EX0;
      end
      EX0: begin
        st_d = INF;
        ps   = PS_INC;
        case (op)
          OP_LD:  begin a_int = abus; dbus = d_in; rf_we = 1'b1; nz_we = 1'b1; end
          OP_ST:  begin a_int = abus; d_int = bbus; wen_int = 1'b0; end
          OP_IN:  begin a_int = abus; iom_int = 1'b1; dbus = io_in; rf_we = 1'b1; nz_we = 1'b1; end
          OP_OUT: begin a_int = abus; d_int = bbus; wen_int = 1'b0; iom_int = 1'b1; end
          OP_LRI: begin a_int = abus; h0_we = 1'b1; ps = PS_HOLD; st_d = EX1; end
          OP_BRZ: if (abus == 16'd0) ps = PS_BR;
          OP_BRN: if (abus[15]) ps = PS_BR;
          OP_JMP: ps = PS_JMP;
          OP_HLT: begin ps = PS_HOLD; st_d = HLT; end
          default: if (fu_alu) begin rf_we = 1'b1; nz_we = 1'b1; end
        endcase
      end
      EX1: begin
        a_int = hb_r[0];
        dbus  = d_in;
        rf_we = 1'b1;
        ps    = PS_INC;
        st_d  = INF;
      end
      default: ;
    endcase
  end

  // Reset forces the bus idle at once so an in-flight store never reaches memory.
  assign a_out   = rst_n ? 16'd0 : a_int;
  assign d_out   = rst_n ? 16'd0 : d_int;
  assign wen_out = rst_n ? 1'b1  : wen_int;
  assign iom_out = rst_n ? 1'b0  : iom_int;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rf_sel
      assign rf_sel[gi] = rf_we && (dr == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n) begin
      st_r <= INF;
      pc_r <= '0;
      ir_r <= '0;
      nz   <= '0;
    end else begin
      st_r <= st_d;
      if (il) ir_r <= d_in;
      case (ps)
        PS_INC:  pc_r <= pc_r + 16'd1;
        PS_BR:   pc_r <= pc_r + br_off;
        PS_JMP:  pc_r <= abus;
        default: ;
      endcase
      if (nz_we) nz <= {dbus[15], dbus == 16'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        rb_r[i] <= '0;
        hb_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (rf_sel[i]) rb_r[i] <= dbus;
      end
      if (h0_we) hb_r[0] <= d_in;
    end
  end
endmodule

// File: tb/tb_my_cpu.sv
// Bench for my_cpu: small programs in a 1K-word memory; stores/OUTs are checked against a queue.
module tb_my_cpu;
  localparam logic [6:0] MOVB = 7'b0001100, INC = 7'b0000001, ADD = 7'b0000010;
  localparam logic [6:0] SUB  = 7'b0000101, DEC = 7'b0000110, AND = 7'b0001000;
  localparam logic [6:0] OR   = 7'b0001001, XOR = 7'b0001010, NOT = 7'b0001011;
  localparam logic [6:0] SHR  = 7'b0001101, SHL = 7'b0001110, LDI = 7'b1001100;
  localparam logic [6:0] ADI  = 7'b1000010, LD  = 7'b0010000, ST  = 7'b0100000;
  localparam logic [6:0] IN   = 7'b0010001, OUT = 7'b0100001, LRI = 7'b0010100;
  localparam logic [6:0] BRZ  = 7'b1100000, BRN = 7'b1100001, JMP = 7'b1110000;
  localparam logic [6:0] HLTI = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b1;
  logic [15:0] d_in;
  logic [15:0] io_in = 16'h1234;
  logic [15:0] a_out, d_out;
  logic        wen_out, iom_out;
  logic [15:0] mem [1024];
  logic [15:0] img [1024];

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        iom;
    logic [1:0]  nz;
  } wr_t;
  wr_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int ep;

  always #5 clk = ~clk;

  my_cpu dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .io_in(io_in),
    .a_out(a_out), .d_out(d_out), .wen_out(wen_out), .iom_out(iom_out)
  );

  assign d_in = (a_out < 16'd1024) ? mem[a_out[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
    end else if (!wen_out && !iom_out && a_out < 16'd1024) begin
      mem[a_out[9:0]] <= d_out;
    end
  end

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endfunction

  // Monitor: every write cycle must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (wen_out === 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: a_out=%h d_out=%h iom=%b", a_out, d_out, iom_out);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", a_out, e.addr);
        chk("wr_data", d_out, e.data);
        chk("wr_iom", {15'd0, iom_out}, {15'd0, e.iom});
        chk("wr_flags", {14'd0, dut.nz}, {14'd0, e.nz});
      end
    end
  end

  function automatic logic [15:0] ins(input logic [6:0] op, input logic [2:0] dr,
                                      input logic [2:0] sa, input logic [2:0] sb);
    return {op, dr, sa, sb};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 16'h0000;
    ep = 0;
  endtask

  task automatic emit(input logic [15:0] w);
    img[ep] = w;
    ep++;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d, input logic iom, input logic [1:0] nz);
    wr_t e;
    e.addr = a; e.data = d; e.iom = iom; e.nz = nz;
    exp_q.push_back(e);
  endtask

  task automatic start_prog();
    @(negedge clk);
    load = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (dut.st_r != 2'd3 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("halted", {14'd0, dut.st_r}, 16'd3);
  endtask

  initial begin
    // Program 1: LDI R1,5; LDI R2,3; ADD R3,R1,R2; HLT
    clear_img();
    emit(ins(LDI, 1, 0, 5));
    emit(ins(LDI, 2, 0, 3));
    emit(ins(ADD, 3, 1, 2));
    emit(ins(HLTI, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_out", a_out, 16'h0000);
    chk("rst_d_out", d_out, 16'h0000);
    chk("rst_wen", {15'd0, wen_out}, 16'd1);
    chk("rst_iom", {15'd0, iom_out}, 16'd0);
    chk("rst_pc", dut.pc_r, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("p1_state_c7", {14'd0, dut.st_r}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    chk("p1_state_c8", {14'd0, dut.st_r}, 16'd3);
    chk("p1_r3", dut.rb_r[3], 16'd8);
    chk("p1_flags", {14'd0, dut.nz}, 16'd0);
    chk("p1_halt_a_out", a_out, 16'd3);

    // Program 2: ALU ops, flags, ST/LD, OUT/IN, LRI; results stored from address 160 up
    clear_img();
    emit(ins(LDI, 1, 0, 5));
    emit(ins(LDI, 2, 0, 3));
    emit(ins(LDI, 7, 0, 5));
    repeat (5) emit(ins(ADD, 7, 7, 7));
    emit(ins(SUB, 3, 1, 1));
    emit(ins(ST, 0, 7, 3));  push(16'd160, 16'h0000, 1'b0, 2'b01);
    emit(ins(INC, 7, 7, 0));
    emit(ins(DEC, 4, 3, 0));
    emit(ins(ST, 0, 7, 4));  push(16'd161, 16'hFFFF, 1'b0, 2'b10);
    emit(ins(INC, 7, 7, 0));
    emit(ins(ADD, 5, 1, 2));
    emit(ins(XOR, 5, 5, 1));
    emit(ins(ST, 0, 7, 5));  push(16'd162, 16'h000D, 1'b0, 2'b00);
    emit(ins(INC, 7, 7, 0));
    emit(ins(NOT, 6, 1, 0));
    emit(ins(SHR, 6, 0, 6));
    emit(ins(ST, 0, 7, 6));  push(16'd163, 16'h7FFD, 1'b0, 2'b00);
    emit(ins(INC, 7, 7, 0));
    emit(ins(AND, 5, 4, 2));
    emit(ins(ADI, 5, 5, 7));
    emit(ins(ST, 0, 7, 5));  push(16'd164, 16'h000A, 1'b0, 2'b00);
    emit(ins(LDI, 2, 0, 7));
    emit(ins(ST, 0, 7, 2));  push(16'd164, 16'h0007, 1'b0, 2'b00);
    emit(ins(LD, 4, 7, 0));
    emit(ins(INC, 7, 7, 0));
    emit(ins(ST, 0, 7, 4));  push(16'd165, 16'h0007, 1'b0, 2'b00);
    emit(ins(ADD, 6, 7, 7));
    emit(ins(ADD, 6, 6, 6));
    emit(ins(LD, 5, 6, 0));
    emit(ins(INC, 6, 6, 0));
    emit(ins(INC, 7, 7, 0));
    emit(ins(LD, 2, 6, 0));
    emit(ins(ST, 0, 7, 2));  push(16'd166, 16'h8000, 1'b0, 2'b10);
    emit(ins(INC, 7, 7, 0));
    emit(ins(SHL, 3, 0, 2));
    emit(ins(ST, 0, 7, 3));  push(16'd167, 16'h0000, 1'b0, 2'b01);
    emit(ins(LDI, 1, 0, 3));
    emit(ins(OUT, 0, 1, 5)); push(16'd3, 16'h00AA, 1'b1, 2'b00);
    emit(ins(INC, 7, 7, 0));
    emit(ins(IN, 4, 1, 0));
    emit(ins(ST, 0, 7, 4));  push(16'd168, 16'h1234, 1'b0, 2'b00);
    emit(ins(INC, 6, 6, 0));
    emit(ins(INC, 7, 7, 0));
    emit(ins(LRI, 2, 6, 0));
    emit(ins(ST, 0, 7, 2));  push(16'd169, 16'h5A5A, 1'b0, 2'b00);
    emit(ins(INC, 7, 7, 0));
    emit(ins(OR, 3, 2, 5));
    emit(ins(ST, 0, 7, 3));  push(16'd170, 16'h5AFA, 1'b0, 2'b00);
    emit(ins(INC, 7, 7, 0));
    emit(ins(MOVB, 3, 0, 2));
    emit(ins(ST, 0, 7, 3));  push(16'd171, 16'h5A5A, 1'b0, 2'b00);
    emit(ins(HLTI, 0, 0, 0));
    img[660] = 16'h00AA;
    img[661] = 16'h8000;
    img[662] = 16'd663;
    img[663] = 16'h5A5A;
    start_prog();
    run_to_halt(400);
    chk("p2_queue_drained", 16'(exp_q.size()), 16'd0);
    chk("p2_mem165", mem[165], 16'h0007);
    chk("p2_r4_in", dut.rb_r[4], 16'h1234);

    // Program 3: countdown loop with BRZ/JMP, then BRN with offset -1
    clear_img();
    emit(ins(LDI, 1, 0, 3));
    emit(ins(LDI, 3, 0, 2));
    emit(ins(DEC, 1, 1, 0));
    emit(ins(INC, 2, 2, 0));
    emit(ins(BRZ, 3'b000, 1, 3'b010));
    emit(ins(JMP, 0, 3, 0));
    emit(ins(LDI, 7, 0, 5));
    repeat (3) emit(ins(ADD, 7, 7, 7));
    emit(ins(ST, 0, 7, 2));  push(16'd40, 16'd3, 1'b0, 2'b00);
    emit(ins(INC, 7, 7, 0));
    emit(ins(LDI, 4, 0, 0));
    emit(ins(DEC, 4, 4, 0));
    emit(ins(DEC, 4, 4, 0));
    emit(ins(INC, 4, 4, 0));
    emit(ins(BRN, 3'b111, 4, 3'b111));
    emit(ins(ST, 0, 7, 4));  push(16'd41, 16'd0, 1'b0, 2'b01);
    emit(ins(HLTI, 0, 0, 0));
    start_prog();
    run_to_halt(300);
    chk("p3_r1", dut.rb_r[1], 16'd0);
    chk("p3_pc", dut.pc_r, 16'd18);
    chk("p3_queue_drained", 16'(exp_q.size()), 16'd0);

    // Program 4: reset during EX0 of a store aborts it; the rerun then completes it
    clear_img();
    emit(ins(LDI, 1, 0, 5));
    emit(ins(LDI, 2, 0, 7));
    emit(ins(ST, 0, 1, 2));
    emit(ins(HLTI, 0, 0, 0));
    start_prog();
    repeat (5) @(posedge clk);
    #1;
    chk("p4_store_pending", {15'd0, wen_out}, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("p4_abort_wen", {15'd0, wen_out}, 16'd1);
    chk("p4_abort_a_out", a_out, 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk("p4_pc_cleared", dut.pc_r, 16'd0);
    chk("p4_r2_cleared", dut.rb_r[2], 16'd0);
    chk("p4_state_inf", {14'd0, dut.st_r}, 16'd0);
    chk("p4_mem_untouched", mem[5], 16'd0);
    push(16'd5, 16'd7, 1'b0, 2'b00);
    rst_n = 1'b0;
    run_to_halt(100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("p4_hlt_held", {14'd0, dut.st_r}, 16'd3);
    chk("p4_hlt_pc", dut.pc_r, 16'd3);
    chk("p4_hlt_a_out", a_out, 16'd3);
    chk("p4_mem5", mem[5], 16'd7);
    chk("p4_queue_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
